ram_arbiter: RTL
================

# ram_arbiter

Two-port arbiter and sequencer in front of the single-port synchronous `RAM` block (10-bit word address, 32-bit data, one `WRITE_ENABLE`, one-cycle read latency). It shares that RAM between the instruction-fetch port (IF) and the load/store port (LS) of the RV32I core. It uses round-robin arbitration. It turns byte- and halfword-masked stores into read-modify-write (RMW) sequences, because the RAM supports only full-word writes.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, word-address width; must match the RAM.
- `DATA_WIDTH`, 32, data width; fixed at 32 because `LS_BE` is 4 bits.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `IF_REQ`  in  1  fetch request.
- `IF_ADDR`  in  ADDR_WIDTH  fetch word address.
- `IF_GNT`  out  1  fetch request accepted this cycle.
- `IF_RVALID`  out  1  `IF_RDATA` is valid this cycle.
- `IF_RDATA`  out  32  fetched word.
- `LS_REQ`  in  1  load/store request.
- `LS_WE`  in  1  1 = store, 0 = load.
- `LS_BE`  in  4  store byte enables; bit i enables byte i (bits 8i+7:8i).
- `LS_ADDR`  in  ADDR_WIDTH  load/store word address.
- `LS_WDATA`  in  32  store data, already lane-aligned.
- `LS_GNT`  out  1  LS request accepted this cycle.
- `LS_RVALID`  out  1  `LS_RDATA` is valid this cycle.
- `LS_RDATA`  out  32  loaded word.
- `RAM_ADDRESS`  out  ADDR_WIDTH  drives the RAM address input.
- `RAM_DATA_IN`  out  32  drives the RAM write data.
- `RAM_WRITE_ENABLE`  out  1  drives the RAM write enable.
- `RAM_DATA_OUT`  in  32  RAM read data; valid the cycle after its address was sampled.

## Operation
- FSM states:
  - IDLE: arbitrates each cycle.
  - MERGE: second cycle of an RMW.
- Registers:
  - `state`
  - `prio`: 0 favours LS, 1 favours IF.
  - `if_pend`, `ls_pend`: a read was issued last cycle.
  - RMW latches: address, wdata, BE.
- Arbitration, IDLE only:
  - Only one requester asserts REQ: it is granted.
  - Both assert REQ: the one favoured by `prio` is granted.
  - After any grant, `prio` points to the other port.
  - Reset value of `prio` is 0 (favour LS).
- Grant is combinational from the REQ inputs and registered state. The granted port's address and data drive the RAM in the same cycle.
- Requester rules:
  - Hold REQ and all attributes stable until GNT is sampled high.
  - REQ may be withdrawn before GNT without side effects.
  - Holding REQ after a grant issues a new request.
- Access kinds:
  - IF read, or LS load: RAM read. The matching `*_pend` bit is set for one cycle.
  - LS store, `LS_BE`=1111: single-cycle write. `RAM_WRITE_ENABLE`=1 and `RAM_DATA_IN`=`LS_WDATA`. No RVALID.
  - LS store, `LS_BE`=0000: granted, no RAM write, no RVALID (no-op).
  - LS store with any other BE: RAM read of `LS_ADDR`; latch address, wdata and BE; go to MERGE.
- MERGE:
  - Drive `RAM_ADDRESS` = latched address and `RAM_WRITE_ENABLE`=1.
  - `RAM_DATA_IN` byte i = latched wdata byte i if BE[i] is set, else `RAM_DATA_OUT` byte i.
  - `IF_GNT` and `LS_GNT` are 0.
  - Return to IDLE. `prio` is not changed by MERGE.
- Read return:
  - `X_RVALID` = `x_pend`.
  - `X_RDATA` = `RAM_DATA_OUT` while `X_RVALID`, else 0.
  - RMW reads never raise an RVALID.
- With no grant, `RAM_WRITE_ENABLE`=0. `RAM_ADDRESS` and `RAM_DATA_IN` hold the IF values (don't-care).

## Timing
- Reset while `RESET_N`=0:
  - `state`=IDLE, `prio`=0, both `*_pend`=0.
  - `IF_GNT`, `LS_GNT`, `RAM_WRITE_ENABLE`, both RVALIDs and both RDATA are forced to 0.
- Read: granted in cycle N; RVALID and data in cycle N+1 for exactly one cycle. Back-to-back reads sustain one per cycle.
- Full store: granted in N; memory updated at the end of N.
- Partial store: granted in N; merged write commits at the end of N+1. No grant in N+1; the earliest next grant is in N+2.
- A read of the same address granted in N+2 returns the merged word in N+3.
- Both requesting continuously: grants alternate LS, IF, LS, IF, … starting with LS after reset. An RMW inserts one grant-free cycle.
- Reset in the MERGE cycle (before the N+1 edge): the write is aborted and the word stays unchanged.
- Reset while `*_pend`=1: the pending RVALID is dropped.
- A grant and an RVALID for the same port may coincide (pipelined reads).

## Test plan
- Reset: hold `RESET_N`=0 with both REQs high → both GNTs, both RVALIDs, RDATA and `RAM_WRITE_ENABLE` all 0. First grant after release goes to LS.
- Store then fetch:
  - LS stores 55 to address 1 (BE=1111); LS_GNT for one cycle, no LS_RVALID.
  - IF reads address 1 → IF_RVALID one cycle after IF_GNT with IF_RDATA=55.
- Contention:
  - Setup: mem[1]=55, mem[2]=99; IF reads address 2 and LS loads address 1, REQ held for 6 cycles.
  - Grants alternate LS, IF, LS, IF, LS, IF.
  - Each grant gets RVALID one cycle later: LS data 55, IF data 99.
- Partial store:
  - Setup: mem[2]=0x11223344; LS stores BE=0010, data 0x0000AB00, with IF_REQ held high.
  - IF_GNT stays 0 in the MERGE cycle.
  - A later load of address 2 returns 0x1122AB44.
- Reset in MERGE: same partial store, `RESET_N` pulsed low during the MERGE cycle → after release, a load of address 2 returns 0x11223344.
- Empty mask: LS store with BE=0000 to address 1 → LS_GNT=1, `RAM_WRITE_ENABLE` never 1, no RVALID. Address 1 still reads 55.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Round-robin arbiter between the instruction-fetch port and the
//             load/store port in front of one single-port synchronous RAM
//             (one-cycle read latency, full-word writes only). Byte- and
//             halfword-masked stores become a read-modify-write sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  // instruction-fetch port
  input  logic                  IF_REQ,
  input  logic [ADDR_WIDTH-1:0] IF_ADDR,
  output logic                  IF_GNT,
  output logic                  IF_RVALID,
  output logic [DATA_WIDTH-1:0] IF_RDATA,
  // load/store port
  input  logic                  LS_REQ,
  input  logic                  LS_WE,
  input  logic [3:0]            LS_BE,
  input  logic [ADDR_WIDTH-1:0] LS_ADDR,
  input  logic [DATA_WIDTH-1:0] LS_WDATA,
  output logic                  LS_GNT,
  output logic                  LS_RVALID,
  output logic [DATA_WIDTH-1:0] LS_RDATA,
  // RAM side
  output logic [ADDR_WIDTH-1:0] RAM_ADDRESS,
  output logic [DATA_WIDTH-1:0] RAM_DATA_IN,
  output logic                  RAM_WRITE_ENABLE,
  input  logic [DATA_WIDTH-1:0] RAM_DATA_OUT
);

  localparam logic [3:0] C_BE_FULL = 4'b1111;
  localparam logic [3:0] C_BE_NONE = 4'b0000;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_t;

  state_t                  state_q,     state_d;
  logic                    prio_q,      prio_d;      // 0 favours LS, 1 favours IF
  logic                    if_pend_q,   if_pend_d;
  logic                    ls_pend_q,   ls_pend_d;
  logic [ADDR_WIDTH-1:0]   rmw_addr_q,  rmw_addr_d;
  logic [DATA_WIDTH-1:0]   rmw_wdata_q, rmw_wdata_d;
  logic [3:0]              rmw_be_q,    rmw_be_d;

  logic                    grant_ls;
  logic                    grant_if;
  logic [DATA_WIDTH-1:0]   merged_word;

  // Arbitration decision: a lone requester wins, a tie goes to the prio side.
  always_comb begin
    grant_ls = 1'b0;
    grant_if = 1'b0;
    if (state_q == ST_IDLE) begin
      grant_ls = LS_REQ && (!IF_REQ || !prio_q);
      grant_if = IF_REQ && !grant_ls;
    end
  end

  // Merge latched store bytes over the word the RAM returned for the RMW read.
  always_comb begin
    merged_word = RAM_DATA_OUT;
    for (int i = 0; i < 4; i++) begin
      if (rmw_be_q[i]) begin
        merged_word[8*i +: 8] = rmw_wdata_q[8*i +: 8];
      end
    end
  end

  // Next-state logic and RAM/grant outputs; everything is quiet during reset.
  always_comb begin
    state_d          = state_q;
    prio_d           = prio_q;
    if_pend_d        = 1'b0;
    ls_pend_d        = 1'b0;
    rmw_addr_d       = rmw_addr_q;
    rmw_wdata_d      = rmw_wdata_q;
    rmw_be_d         = rmw_be_q;
    IF_GNT           = 1'b0;
    LS_GNT           = 1'b0;
    RAM_ADDRESS      = IF_ADDR;
    RAM_DATA_IN      = '0;
    RAM_WRITE_ENABLE = 1'b0;

    if (RESET_N) begin
      unique case (state_q)
        ST_IDLE: begin
          if (grant_ls) begin
            LS_GNT      = 1'b1;
            prio_d      = 1'b1;
            RAM_ADDRESS = LS_ADDR;
            if (!LS_WE) begin
              ls_pend_d = 1'b1;
            end else if (LS_BE == C_BE_FULL) begin
              RAM_WRITE_ENABLE = 1'b1;
              RAM_DATA_IN      = LS_WDATA;
            end else if (LS_BE != C_BE_NONE) begin
              // Partial store: this cycle reads the old word, MERGE writes it.
              rmw_addr_d  = LS_ADDR;
              rmw_wdata_d = LS_WDATA;
              rmw_be_d    = LS_BE;
              state_d     = ST_MERGE;
            end
          end else if (grant_if) begin
            IF_GNT      = 1'b1;
            prio_d      = 1'b0;
            RAM_ADDRESS = IF_ADDR;
            if_pend_d   = 1'b1;
          end
        end
        ST_MERGE: begin
          RAM_ADDRESS      = rmw_addr_q;
          RAM_DATA_IN      = merged_word;
          RAM_WRITE_ENABLE = 1'b1;
          state_d          = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      if_pend_q   <= 1'b0;
      ls_pend_q   <= 1'b0;
      rmw_addr_q  <= '0;
      rmw_wdata_q <= '0;
      rmw_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      if_pend_q   <= if_pend_d;
      ls_pend_q   <= ls_pend_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_wdata_q <= rmw_wdata_d;
      rmw_be_q    <= rmw_be_d;
    end
  end

  // Read return: RAM data is steered to whichever port issued last cycle's read.
  always_comb begin
    IF_RVALID = if_pend_q;
    LS_RVALID = ls_pend_q;
    IF_RDATA  = if_pend_q ? RAM_DATA_OUT : '0;
    LS_RDATA  = ls_pend_q ? RAM_DATA_OUT : '0;
  end

endmodule
`default_nettype wire
